// File: rtl/nios_system_led_sequencer_if.sv
// Avalon-style slave bus bundle for the LED sequencer.
// Ports: address, chipselect, write_n, writedata (to slave); readdata (from slave).
interface nios_system_led_sequencer_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/nios_system_led_sequencer.sv
// LED pattern sequencer: steps out_port through PATTERN0..3, each held
// STEP ticks of PRESCALE clocks; optional done interrupt (LED_SEQ_IRQ_EN).
// Ports: clk, reset (sync, active-high), s (bus slave), out_port[7:0], irq.
module nios_system_led_sequencer #(
    parameter int unsigned PRESCALE = 50000
) (
    input  logic                           clk,
    input  logic                           reset,
    nios_system_led_sequencer_if.slave     s,
    output logic [7:0]                     out_port,
    output logic                           irq
);

    localparam int unsigned PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PMAX = PW'(PRESCALE - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SHOW = 1'b1;

    logic [0:0]    state;
    logic [1:0]    idx;
    logic [PW-1:0] presc;
    logic [15:0]   dwell;
    logic [15:0]   step;
    logic [7:0]    pattern [4];
    logic          ctrl_run;
    logic          ctrl_loop;
    logic          ctrl_irq_en;
    logic          done;

    logic        wr_en;
    logic        wr_ctrl;
    logic        wr_stat;
    logic        wr_step;
    logic        wr_pat;
    logic        start;
    logic        stop;
    logic        tick;
    logic        expire;
    logic        finish;
    logic [15:0] step_eff;
    logic        run_nxt;
    logic        loop_nxt;
    logic        ien_nxt;
    logic        done_nxt;
    logic        irq_nxt;
    logic        unused_wd;

    assign unused_wd = ^s.writedata[31:16];

    assign wr_en   = s.chipselect & ~s.write_n;
    assign wr_ctrl = wr_en && (s.address == 3'd0);
    assign wr_stat = wr_en && (s.address == 3'd1);
    assign wr_step = wr_en && (s.address == 3'd2);
    assign wr_pat  = wr_en && s.address[2];

    assign start = wr_ctrl && s.writedata[0] && (state == IDLE);
    // Stop outranks any expiry landing on the same edge.
    assign stop  = wr_ctrl && !s.writedata[0] && (state == SHOW);

    assign tick   = (state == SHOW) && (presc == PMAX);
    // dwell is always >= 1 while showing; <= 1 guards a stray 0.
    assign expire = tick && (dwell <= 16'd1);
    assign finish = expire && !stop && (idx == 2'd3) && !ctrl_loop;

    assign step_eff = (step == 16'd0) ? 16'd1 : step;

    always_comb begin
        run_nxt  = ctrl_run;
        loop_nxt = ctrl_loop;
        done_nxt = done;
        if (wr_ctrl) begin
            run_nxt  = s.writedata[0];
            loop_nxt = s.writedata[1];
        end
        if (wr_stat && s.writedata[1]) begin
            done_nxt = 1'b0;
        end
        // Completion beats a same-cycle done clear.
        if (finish) begin
            run_nxt  = 1'b0;
            done_nxt = 1'b1;
        end
    end

`ifdef LED_SEQ_IRQ_EN
    always_comb begin
        ien_nxt = ctrl_irq_en;
        if (wr_ctrl) begin
            ien_nxt = s.writedata[2];
        end
        irq_nxt = done_nxt & ien_nxt;
    end
`else
    always_comb begin
        ien_nxt = 1'b0;
        irq_nxt = 1'b0;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            idx         <= 2'd0;
            presc       <= '0;
            dwell       <= 16'd0;
            step        <= 16'd1;
            ctrl_run    <= 1'b0;
            ctrl_loop   <= 1'b0;
            ctrl_irq_en <= 1'b0;
            done        <= 1'b0;
            irq         <= 1'b0;
            out_port    <= 8'd0;
            for (int i = 0; i < 4; i++) begin
                pattern[i] <= 8'd0;
            end
        end else begin
            ctrl_run    <= run_nxt;
            ctrl_loop   <= loop_nxt;
            ctrl_irq_en <= ien_nxt;
            done        <= done_nxt;
            irq         <= irq_nxt;

            if (wr_step) begin
                step <= s.writedata[15:0];
            end
            if (wr_pat) begin
                pattern[s.address[1:0]] <= s.writedata[7:0];
            end

            if (state == SHOW) begin
                presc <= tick ? '0 : presc + 1'b1;
            end

            if (start) begin
                state    <= SHOW;
                idx      <= 2'd0;
                out_port <= pattern[0];
                presc    <= '0;
                dwell    <= step_eff;
            end else if (stop) begin
                state <= IDLE;
            end else if (expire) begin
                if (idx != 2'd3) begin
                    idx      <= idx + 2'd1;
                    out_port <= pattern[idx + 2'd1];
                    dwell    <= step_eff;
                end else if (ctrl_loop) begin
                    idx      <= 2'd0;
                    out_port <= pattern[0];
                    dwell    <= step_eff;
                end else begin
                    state <= IDLE;
                end
            end else if (tick) begin
                dwell <= dwell - 16'd1;
            end
        end
    end

    always_comb begin
        s.readdata = 32'd0;
        case (s.address)
            3'd0: s.readdata = {29'd0, ctrl_irq_en, ctrl_loop, ctrl_run};
            3'd1: s.readdata = {28'd0, idx, done, state == SHOW};
            3'd2: s.readdata = {16'd0, step};
            3'd4: s.readdata = {24'd0, pattern[0]};
            3'd5: s.readdata = {24'd0, pattern[1]};
            3'd6: s.readdata = {24'd0, pattern[2]};
            3'd7: s.readdata = {24'd0, pattern[3]};
            default: s.readdata = 32'd0;
        endcase
    end

endmodule

// File: doc/nios_system_led_sequencer.md
NIOS_SYSTEM_LED_SEQUENCER -- requirements
Module: nios_system_led_sequencer

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 The block SHALL provide parameter PRESCALE, default 50000, clk cycles per tick (minimum 1).
REQ-003 The block SHALL provide these ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- address  in  3  register select
- chipselect  in  1  slave select
- write_n  in  1  active-low write strobe
- writedata  in  32  write data
- readdata  out  32  read data, combinational, zero wait states
- out_port  out  8  LED drive
- irq  out  1  sequence-done interrupt, level

Function
REQ-004 The block SHALL implement this register map; unmapped addresses read 0 and ignore writes:
- 0 CONTROL: bit0 run, bit1 loop, bit2 irq_en
- 1 STATUS: bit0 busy (RO), bit1 done (write 1 to clear), bits3:2 current index (RO)
- 2 STEP: bits15:0 dwell in ticks; a value of 0 is treated as 1
- 4..7 PATTERN0..3: bits7:0
REQ-005 A write SHALL occur when chipselect=1 and write_n=0, taking effect on the next clk edge.
REQ-006 The FSM SHALL have two states, IDLE and SHOW.
REQ-007 In IDLE, writing CONTROL with run=1 SHALL, on the next edge, enter SHOW with idx=0, set out_port=PATTERN0, clear the prescaler and load the dwell counter.
REQ-008 The prescaler SHALL count 0..PRESCALE-1 in SHOW only, and emit a one-cycle tick on wrap.
REQ-009 Each tick in SHOW SHALL decrement the dwell counter; the step expires on the tick that moves the counter from 1 to 0.
REQ-010 On expiry with idx<3, the block SHALL set idx+1, drive out_port=PATTERN[idx+1] and reload the dwell counter.
REQ-011 On expiry with idx=3 and loop=1, the block SHALL wrap idx to 0, drive PATTERN0 and reload the dwell counter.
REQ-012 On expiry with idx=3 and loop=0, the block SHALL enter IDLE, clear the run bit, set done and hold out_port.
REQ-013 Writing run=0 in SHOW SHALL return to IDLE on the next edge, hold out_port and leave done unchanged; stop wins over a simultaneous expiry.
REQ-014 Writing run=1 while already in SHOW SHALL NOT restart the sequence.
REQ-015 A PATTERN write during SHOW SHALL update storage only; it appears on out_port the next time that index is loaded.
REQ-016 A STEP write during SHOW SHALL apply at the next reload.
REQ-017 If done-set and a done-clear write occur in the same cycle, set SHALL win.
REQ-018 busy SHALL read 1 exactly when the state is SHOW.
REQ-019 Every output transition SHALL be registered, with one edge of latency from its cause.

Reset
REQ-020 Reset SHALL set state=IDLE, idx=0, prescaler=0, dwell=0, CONTROL=0, done=0, STEP=1, PATTERN0..3=0, out_port=0 and irq=0.
REQ-021 Reset asserted mid-SHOW SHALL take priority over all other activity in that cycle.

Configuration
REQ-022 With macro LED_SEQ_IRQ_EN defined, the block SHALL drive irq = done AND irq_en, with CONTROL bit2 read/write.
REQ-023 Without LED_SEQ_IRQ_EN, irq SHALL be tied 0 and CONTROL bit2 SHALL read 0 and ignore writes; all other behaviour is identical.

Verification (PRESCALE=2)
REQ-024 The bench SHALL cover these directed scenarios:
- PATTERN0..3=01,02,04,08; STEP=3; CONTROL=1 -> out_port steps 01,02,04,08, each held 6 cycles; then busy=0, done=1, out_port stays 08.
- Same setup with CONTROL=3 -> after 08 out_port returns to 01, busy stays 1, done stays 0.
- Write CONTROL=0 during the 02 step -> IDLE next edge, out_port holds 02, done=0; CONTROL=1 then restarts at 01.
- STEP=0 -> each pattern held 2 cycles; a STATUS write of 0x2 in the same cycle as the final expiry -> done reads 1.
- LED_SEQ_IRQ_EN defined, CONTROL=5 -> irq=1 at completion; STATUS write of 0x2 -> irq=0 next edge.
- Reset asserted mid-SHOW -> next edge out_port=00, readdata at address 4 reads 0, busy=0.
